// File: rtl/alu_share_pkg.sv
// Shared types and helpers for the ALU sharing controller.
// Holds the sequencing state enum, the default datapath widths and the
// owner-index width helper used by the top and the arbiter.
package alu_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int W_DEF   = 7;
  localparam int OPW_DEF = 2;

  // Width of an encoded requester index; never below one bit.
  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Ports:
//   req_i   requester request vector
//   last_i  index of the last requester served
//   gnt_o   one-hot grant (all zero when no request)
//   idx_o   encoded index of the granted requester
//   any_o   1 when some requester is granted
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  int unsigned cand;

  // Search starts one past the last owner and wraps around.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_i) + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!any_o && (cand == j) && req_i[j]) begin
          any_o    = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between NREQ requesters.
// Requests are granted round-robin, operands are registered and drive the
// ALU for one EXEC cycle, and the captured result is returned to its owner.
//
// state | meaning
// IDLE  | waiting for a request; grant offered to round-robin winner
// EXEC  | registered operands on the ALU; capture result next edge
// RESP  | result offered to the owner until accepted
//
// Ports:
//   clk, rst              clock, async active-low reset
//   req_valid/ready       per-requester operation handshake
//   req_a/req_b/req_op    packed per-requester operands and opcode
//   rsp_valid/ready       per-requester result handshake
//   rsp_r, rsp_zero       registered result and zero flag
//   alu_a/alu_b/alu_op    to the shared ALU
//   alu_r                 from the shared ALU
//   busy                  1 whenever not IDLE
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = W_DEF,
  parameter int OPW  = OPW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [W-1:0]        rsp_r,
  output logic                rsp_zero,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [OPW-1:0]      alu_op,
  input  logic [W-1:0]        alu_r,
  output logic                busy
);

  localparam int IW = owner_w(NREQ);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OPW-1:0]  op_q, op_d;
  logic            zero_q, zero_d;
  logic [IW-1:0]   owner_q, owner_d, last_q, last_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    zero_d    = zero_q;
    owner_d   = owner_q;
    last_d    = last_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        if (gnt_any) begin
          // gnt is one-hot, so exactly one slice is picked up.
          for (int j = 0; j < NREQ; j++) begin
            if (gnt[j]) begin
              a_d  = req_a[j*W +: W];
              b_d  = req_b[j*W +: W];
              op_d = req_op[j*OPW +: OPW];
            end
          end
          owner_d = gnt_idx;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_r;
        zero_d  = (alu_r == '0);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        for (int j = 0; j < NREQ; j++) begin
          if (owner_q == IW'(j)) rsp_valid[j] = 1'b1;
        end
        // Only the owner's accept counts; rsp_valid masks the others.
        if (|(rsp_valid & rsp_ready)) begin
          last_d  = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      owner_q <= '0;
      // Pointing at the last requester makes requester 0 win first.
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign rsp_r    = res_q;
  assign rsp_zero = zero_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

  localparam int NREQ = 2;
  localparam int W    = 7;
  localparam int OPW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a = '0;
  logic [NREQ*W-1:0]   req_b = '0;
  logic [NREQ*OPW-1:0] req_op = '0;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready = '0;
  logic [W-1:0]        rsp_r;
  logic                rsp_zero;
  logic [W-1:0]        alu_a, alu_b, alu_r;
  logic [OPW-1:0]      alu_op;
  logic                busy;

  int tests = 0;
  int fails = 0;

  alu_share_ctrl #(.NREQ(NREQ), .W(W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Bench ALU: add, or, and, xor, all modulo 2^7.
  function automatic logic [6:0] alu_fn(input logic [6:0] a, input logic [6:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd0:    return 7'((int'(a) + int'(b)) % 128);
      2'd1:    return a | b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_r = alu_fn(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int r, input logic [6:0] a, input logic [6:0] b,
                         input logic [1:0] op);
    if (r == 0) begin
      req_a[6:0] = a; req_b[6:0] = b; req_op[1:0] = op;
    end else begin
      req_a[13:7] = a; req_b[13:7] = b; req_op[3:2] = op;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_rsp_r", 32'(rsp_r), 32'd0);
    chk("rst_zero", 32'(rsp_zero), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  typedef struct {
    int         r;
    logic [6:0] a;
    logic [6:0] b;
    logic [1:0] op;
    logic [6:0] exp_r;
    logic       exp_z;
  } vec_t;

  vec_t vecs[6];

  // Single isolated operation on requester r; starts just after a posedge.
  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = (v.r == 0) ? 2'b01 : 2'b10;
    set_req(v.r, v.a, v.b, v.op);
    req_valid = oh;
    rsp_ready = '0;
    #4;
    chk("v_ready", 32'(req_ready), 32'(oh));
    chk("v_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    set_req(v.r, 7'h7F, 7'h00, 2'd3);
    #4;
    chk("v_alu_a", 32'(alu_a), 32'(v.a));
    chk("v_alu_b", 32'(alu_b), 32'(v.b));
    chk("v_alu_op", 32'(alu_op), 32'(v.op));
    chk("v_exec_rspv", 32'(rsp_valid), 32'd0);
    chk("v_exec_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rsp_ready = oh;
    #4;
    chk("v_rspv", 32'(rsp_valid), 32'(oh));
    chk("v_rsp_r", 32'(rsp_r), 32'(v.exp_r));
    chk("v_rsp_zero", 32'(rsp_zero), 32'(v.exp_z));
    @(posedge clk); #1;
    rsp_ready = '0;
    #4;
    chk("v_back_idle", 32'(busy), 32'd0);
    chk("v_hold_r", 32'(rsp_r), 32'(v.exp_r));
    chk("v_hold_a", 32'(alu_a), 32'(v.a));
    @(posedge clk); #1;
  endtask

  // Reference model state for the random phase.
  int         m_last;
  bit         m_pend;
  int         m_own;
  int         m_age;
  logic [6:0] m_a, m_r;

  initial begin
    vecs[0] = '{0, 7'h15, 7'h0A, 2'd1, 7'h1F, 1'b0};
    vecs[1] = '{0, 7'h15, 7'h0A, 2'd2, 7'h00, 1'b1};
    vecs[2] = '{1, 7'h7F, 7'h01, 2'd0, 7'h00, 1'b1};
    vecs[3] = '{1, 7'h3C, 7'h0F, 2'd3, 7'h33, 1'b0};
    vecs[4] = '{0, 7'h40, 7'h25, 2'd0, 7'h65, 1'b0};
    vecs[5] = '{1, 7'h55, 7'h55, 2'd3, 7'h00, 1'b1};

    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Contention: both valid, immediate accept -> grants 0,1,0,1 every 3 cycles.
    do_reset();
    set_req(0, 7'h01, 7'h02, 2'd0);
    set_req(1, 7'h10, 7'h20, 2'd0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] who;
      who = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
      #4;
      chk("c_ready", 32'(req_ready), (k % 3 == 0) ? 32'(who) : 32'd0);
      chk("c_rspv", 32'(rsp_valid), (k % 3 == 2) ? 32'(who) : 32'd0);
      if (k % 3 == 2) chk("c_rsp_r", 32'(rsp_r), (who == 2'b01) ? 32'h03 : 32'h30);
      @(posedge clk); #1;
    end

    // Backpressure with a competing request and a non-owner accept.
    do_reset();
    set_req(0, 7'h15, 7'h0A, 2'd0);
    set_req(1, 7'h11, 7'h22, 2'd1);
    req_valid = 2'b01;
    #4;
    chk("b_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      rsp_ready = (k == 5) ? 2'b10 : 2'b00;
      #4;
      chk("b_rspv", 32'(rsp_valid), 32'h1);
      chk("b_rsp_r", 32'(rsp_r), 32'h1F);
      chk("b_ready0", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b01;
    #4;
    chk("b_rspv_rel", 32'(rsp_valid), 32'h1);
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    #4;
    chk("b_idle", 32'(busy), 32'd0);
    chk("b_next_rr", 32'(req_ready), 32'h2);

    // Reset in the middle of EXEC.
    do_reset();
    set_req(1, 7'h2A, 7'h01, 2'd0);
    req_valid = 2'b10;
    @(posedge clk); #2;
    chk("m_in_exec", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("m_busy", 32'(busy), 32'd0);
    chk("m_rspv", 32'(rsp_valid), 32'd0);
    chk("m_alu_a", 32'(alu_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b11;
    #4;
    chk("m_first0", 32'(req_ready), 32'h1);
    chk("m_no_stale", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    #4;
    chk("m_exec_rspv", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    #4;
    chk("m_rspv", 32'(rsp_valid), 32'h1);
    @(posedge clk); #1;

    // Random traffic against a transaction-level model.
    do_reset();
    m_last = NREQ - 1;
    m_pend = 0;
    m_own  = 0;
    m_age  = 0;
    m_a    = '0;
    m_r    = '0;
    for (int c = 0; c < 400; c++) begin
      logic [1:0] exp_ready, exp_rv;
      int gi;
      req_valid = 2'($urandom);
      req_a     = 14'($urandom);
      req_b     = 14'($urandom);
      req_op    = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      #4;
      exp_ready = '0;
      exp_rv    = '0;
      gi        = -1;
      if (!m_pend) begin
        for (int k = 1; k <= NREQ; k++) begin
          int g;
          g = (m_last + k) % NREQ;
          if (gi < 0 && req_valid[g]) gi = g;
        end
        if (gi >= 0) exp_ready = 2'(1 << gi);
      end else if (m_age >= 1) begin
        exp_rv = 2'(1 << m_own);
      end
      chk("r_ready", 32'(req_ready), 32'(exp_ready));
      chk("r_rspv", 32'(rsp_valid), 32'(exp_rv));
      chk("r_busy", 32'(busy), 32'(m_pend));
      if (m_pend) chk("r_alu_a", 32'(alu_a), 32'(m_a));
      if (m_pend && m_age >= 1) chk("r_rsp_r", 32'(rsp_r), 32'(m_r));
      if (m_pend && m_age >= 1) chk("r_zero", 32'(rsp_zero), 32'(m_r == 0));
      if (!m_pend) begin
        if (gi >= 0) begin
          logic [6:0] a, b;
          logic [1:0] op;
          a  = (gi == 0) ? req_a[6:0] : req_a[13:7];
          b  = (gi == 0) ? req_b[6:0] : req_b[13:7];
          op = (gi == 0) ? req_op[1:0] : req_op[3:2];
          m_pend = 1;
          m_age  = 0;
          m_own  = gi;
          m_a    = a;
          m_r    = alu_fn(a, b, op);
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (rsp_ready[m_own]) begin
        m_pend = 0;
        m_last = m_own;
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Arbitration and sequencing controller that shares the single combinational 7-bit ALU between NREQ independent requesters.
- Each requester offers an operation (A, B, OP) over a valid/ready handshake.
- The block grants round-robin, drives the ALU from registered operands, captures the result plus a zero flag, and returns it over a per-requester response handshake.
- Sits between requester controllers and the ALU instance inside the top level.

Parameters:
- NREQ, 2, number of requesters (2..4).
- W, 7, operand/result width (matches ALU).
- OPW, 2, ALU opcode width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  NREQ  per-requester operation request.
- req_ready  output  NREQ  one-hot grant/accept strobe.
- req_a  input  NREQ*W  operand A, requester i at bits [i*W +: W].
- req_b  input  NREQ*W  operand B, same packing.
- req_op  input  NREQ*OPW  opcode, requester i at [i*OPW +: OPW].
- rsp_valid  output  NREQ  one-hot result-available to owner.
- rsp_ready  input  NREQ  per-requester result accept.
- rsp_r  output  W  registered ALU result.
- rsp_zero  output  1  registered flag, 1 when rsp_r == 0.
- alu_a  output  W  to ALU A.
- alu_b  output  W  to ALU B.
- alu_op  output  OPW  to ALU OP.
- alu_r  input  W  from ALU R (combinational).
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; operand/opcode/result/owner regs=0; rsp_zero=0; rr pointer set so requester 0 has highest priority first; all req_ready/rsp_valid=0.
- Effect of the reset values on the ALU outputs: alu_a/alu_b/alu_op=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner g = first asserted req_valid searching from (last_owner+1) mod NREQ.
  - req_ready[g]=1 combinationally (only in IDLE, only for winner, only if req_valid[g]).
  - On valid&ready: latch req_a/b/op slice g into regs, owner<=g, go EXEC.
  - No valid: stay IDLE.
- EXEC (1 cycle):
  - ALU inputs are driven from the registered operands at all times, so they are stable during this cycle.
  - result<=alu_r, rsp_zero<=(alu_r==0), go RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_r/rsp_zero held stable.
  - On rsp_ready[owner]: last_owner<=owner, go IDLE.
  - rsp_ready from non-owners is ignored.
  - Holds indefinitely under backpressure; no new grant meanwhile.
- Latency: handshake cycle -> EXEC next cycle -> rsp_valid the cycle after. Minimum 3 cycles per operation (IDLE, EXEC, RESP with immediate accept).
- Outputs alu_a/b/op, rsp_r, rsp_zero are register-driven and hold their last value in IDLE.
- req_valid dropping before grant is legal and costs nothing. Operands are sampled only on the handshake edge; later changes to req_* do not affect the operation in flight.
- Fairness: a requester holding valid continuously is granted within NREQ operations.
- Reset mid-operation: immediate return to reset values. The in-flight op is discarded and no response is issued.
- Invalid owner index is impossible (NREQ≤4, owner width clog2(NREQ)).

Decomposition:
- Package alu_share_pkg: state enum {IDLE, EXEC, RESP}, W/OPW defaults, owner index width function.
- Sub-module rr_arbiter (NREQ): inputs req vector and last_owner; outputs one-hot grant and encoded index. Purely combinational.

Test Plan:
- Single op: after reset, req_valid=01, a0=7'h15, b0=7'h0A, op0=2'b01.
  - Required: req_ready=01 same cycle; alu_a=15/alu_b=0A/alu_op=1 next cycle.
  - Bench ALU model returns 7'h1F; next cycle rsp_valid=01, rsp_r=1F, rsp_zero=0.
- Zero flag: bench ALU returns 0 -> rsp_zero=1 with rsp_valid.
- Contention: req_valid=11 continuously with immediate rsp_ready.
  - Required: grants alternate 0,1,0,1.
  - Each response goes to the matching owner; one response per 3 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - Required: rsp_valid, rsp_r stable and req_ready=00 throughout.
  - Non-owner rsp_ready=1 has no effect; release -> IDLE.
- Operand change: change a0 to 7'h7F the cycle after the handshake -> alu_a stays 15.
- Reset mid-EXEC: drive rst=0 asynchronously.
  - Required: busy=0, rsp_valid=00, alu_a=0 immediately.
  - After release, requester 0 wins first with no stale response.
